// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: opcode map, ALU/non-ALU split
// and fetch FSM state encoding.
package fetch_unit_pkg;

  localparam int unsigned NIB_WIDTH = 4;

  localparam logic [NIB_WIDTH-1:0] OP_ADD  = 4'h0;
  localparam logic [NIB_WIDTH-1:0] OP_SUB  = 4'h1;
  localparam logic [NIB_WIDTH-1:0] OP_AND  = 4'h2;
  localparam logic [NIB_WIDTH-1:0] OP_OR   = 4'h3;
  localparam logic [NIB_WIDTH-1:0] OP_XOR  = 4'h4;
  localparam logic [NIB_WIDTH-1:0] OP_SHL  = 4'h5;
  localparam logic [NIB_WIDTH-1:0] OP_SHR  = 4'h6;
  localparam logic [NIB_WIDTH-1:0] OP_CMP  = 4'h7;
  localparam logic [NIB_WIDTH-1:0] OP_LD   = 4'h8;
  localparam logic [NIB_WIDTH-1:0] OP_ST   = 4'h9;
  localparam logic [NIB_WIDTH-1:0] OP_LI   = 4'hA;
  localparam logic [NIB_WIDTH-1:0] OP_BEQ  = 4'hB;
  localparam logic [NIB_WIDTH-1:0] OP_BNE  = 4'hC;
  localparam logic [NIB_WIDTH-1:0] OP_JMP  = 4'hD;
  localparam logic [NIB_WIDTH-1:0] OP_JAL  = 4'hE;
  localparam logic [NIB_WIDTH-1:0] OP_HALT = 4'hF;

  // Opcodes below this value are executed by the ALU.
  localparam logic [NIB_WIDTH-1:0] OP_FIRST_NONALU = OP_LD;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_WAIT = 1'b1
  } fetch_state_e;

  function automatic logic is_alu_op(input logic [NIB_WIDTH-1:0] op);
    return op < OP_FIRST_NONALU;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, IR and req/ack handshake to instruction memory.
// Optional fetch timeout enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH     = 8,
  parameter int unsigned           INSTR_WIDTH    = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
  parameter int unsigned           TIMEOUT_CYCLES = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   do_fetch,
  input  logic                   do_next,
  input  logic                   jump_en,
  input  logic [ADDR_WIDTH-1:0]  jump_target,
  output logic                   mem_req,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic                   mem_ack,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [NIB_WIDTH-1:0]   opcode,
  output logic                   isaluop,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic                   busy,
  output logic                   fetch_err
);

  fetch_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic                   mem_req_c;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               fetch_err_q, fetch_err_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    ir_d      = ir_q;
    mem_req_c = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    timer_d     = timer_q;
    fetch_err_d = fetch_err_q;
`endif

    case (state_q)
      FETCH_IDLE: begin
        mem_req_c = do_fetch;
`ifdef FETCH_TIMEOUT_EN
        timer_d = '0;
`endif
        if (do_fetch) begin
          addr_d = pc_q;
          if (!mem_ack) state_d = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        mem_req_c = 1'b1;
        if (mem_ack) begin
          state_d = FETCH_IDLE;
        end
`ifdef FETCH_TIMEOUT_EN
        // timer_q holds the number of completed WAIT cycles; abort on the last allowed one.
        else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = FETCH_IDLE;
          ir_d        = '0;
          fetch_err_d = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
`endif
      end
      default: state_d = FETCH_IDLE;
    endcase

    if (mem_req_c && mem_ack) ir_d = mem_rdata;

    if (do_next) pc_d = jump_en ? jump_target : pc_q + ADDR_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q     <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      fetch_err_q <= fetch_err_d;
    end
  end
  assign fetch_err = fetch_err_q;
`else
  assign fetch_err = 1'b0;
`endif

  assign mem_req  = mem_req_c;
  assign mem_addr = (state_q == FETCH_WAIT) ? addr_q : pc_q;
  assign busy     = (state_q == FETCH_WAIT);
  assign pc       = pc_q;
  assign instr    = ir_q;
  assign opcode   = ir_q[INSTR_WIDTH-1 -: NIB_WIDTH];
  assign isaluop  = is_alu_op(opcode);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: random fetch/next traffic against a PC/memory model.
// Define FETCH_TIMEOUT_EN to also exercise the timeout path.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam int unsigned AW = 8;
  localparam int unsigned IW = 16;
  localparam logic [AW-1:0] RST_PC = 8'h00;

  logic          clk = 1'b0;
  logic          reset;
  logic          do_fetch, do_next, jump_en;
  logic [AW-1:0] jump_target;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [IW-1:0] mem_rdata;
  logic [IW-1:0] instr;
  logic [3:0]    opcode;
  logic          isaluop;
  logic [AW-1:0] pc;
  logic          busy;
  logic          fetch_err;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_WIDTH    (AW),
    .INSTR_WIDTH   (IW),
    .RESET_PC      (RST_PC),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .do_fetch   (do_fetch),
    .do_next    (do_next),
    .jump_en    (jump_en),
    .jump_target(jump_target),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .instr      (instr),
    .opcode     (opcode),
    .isaluop    (isaluop),
    .pc         (pc),
    .busy       (busy),
    .fetch_err  (fetch_err)
  );

  logic [IW-1:0] imem [256];
  logic [IW-1:0] exp_q [$];
  logic [AW-1:0] model_pc;
  int unsigned   n_checks = 0;
  int unsigned   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    do_fetch = 1'b0; do_next = 1'b0; jump_en = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic advance_pc(input logic nxt, input logic jmp, input logic [AW-1:0] tgt);
    if (nxt) model_pc = jmp ? tgt : model_pc + 8'd1;
  endtask

  task automatic next_op(input logic jmp, input logic [AW-1:0] tgt);
    do_next = 1'b1; jump_en = jmp; jump_target = tgt;
    step();
    advance_pc(1'b1, jmp, tgt);
    clear_inputs();
    chk("pc_after_next", pc, model_pc);
  endtask

  // mode: 0 quiet WAIT, 1 random do_next/do_fetch noise in WAIT, 2 do_next in first WAIT cycle
  task automatic fetch(input logic nxt, input logic jmp, input logic [AW-1:0] tgt,
                       input int unsigned lat, input int unsigned mode);
    logic [AW-1:0] a;
    a = model_pc;
    exp_q.push_back(imem[a]);
    do_fetch = 1'b1; do_next = nxt; jump_en = jmp; jump_target = tgt;
    #1;
    chk("req_issue", mem_req, 1);
    chk("addr_issue", mem_addr, a);
    if (lat == 0) begin mem_ack = 1'b1; mem_rdata = imem[mem_addr]; end
    step();
    advance_pc(nxt, jmp, tgt);
    clear_inputs();
    for (int unsigned k = 1; k <= lat; k++) begin
      #1;
      chk("busy_wait", busy, 1);
      chk("req_wait", mem_req, 1);
      chk("addr_wait", mem_addr, a);
      chk("pc_wait", pc, model_pc);
      if (mode == 1) begin
        do_next = 1'($urandom_range(0, 1)); jump_en = 1'($urandom_range(0, 1));
        jump_target = 8'($urandom); do_fetch = 1'($urandom_range(0, 1));
      end else if (mode == 2 && k == 1) begin
        do_next = 1'b1;
      end
      if (k == lat) begin mem_ack = 1'b1; mem_rdata = imem[mem_addr]; end
      step();
      advance_pc(do_next, jump_en, jump_target);
      clear_inputs();
    end
    chk("busy_done", busy, 0);
    chk("pc_done", pc, model_pc);
  endtask

  // Monitor: any accepted handshake must deliver the next expected instruction into IR.
  logic [IW-1:0] e;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && mem_req && mem_ack) begin
        @(posedge clk);
        #2;
        if (exp_q.size() == 0) begin
          chk("unexpected_capture", instr, 0);
        end else begin
          e = exp_q.pop_front();
          chk("instr", instr, e);
          chk("opcode", opcode, e[15:12]);
          chk("isaluop", isaluop, e[15:12] < 4'd8);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 16'($urandom);
    imem[0] = 16'h3A12;
    reset = 1'b1; jump_target = '0; mem_rdata = '0;
    clear_inputs();
    model_pc = RST_PC;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_pc", pc, RST_PC);
    chk("rst_instr", instr, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", fetch_err, 0);
    reset = 1'b0;
    step();

    // Zero-wait fetch at PC 0
    fetch(1'b0, 1'b0, 8'h00, 0, 0);
    chk("zw_opcode", opcode, 4'h3);
    chk("zw_isaluop", isaluop, 1);

    // Reset while a fetch is outstanding, then a late ack
    next_op(1'b1, 8'h33);
    do_fetch = 1'b1;
    step();
    do_fetch = 1'b0;
    #1;
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_req", mem_req, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_req", mem_req, 0);
    chk("midrst_pc", pc, RST_PC);
    chk("midrst_instr", instr, 0);
    chk("midrst_busy", busy, 0);
    model_pc = RST_PC;
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    step();
    reset = 1'b0;
    step();
    step();
    chk("late_ack_instr", instr, 0);
    chk("late_ack_busy", busy, 0);
    mem_ack = 1'b0;

    // PC wrap and jump
    next_op(1'b1, 8'hFF);
    next_op(1'b0, 8'h00);
    chk("wrap_pc", pc, 8'h00);
    next_op(1'b1, 8'h10);
    next_op(1'b1, 8'h42);
    chk("jump_pc", pc, 8'h42);

    // Fetch and next together
    next_op(1'b1, 8'h20);
    fetch(1'b1, 1'b0, 8'h00, 0, 0);
    chk("fetch_next_pc", pc, 8'h21);

    // Ack three cycles late with do_next during WAIT
    next_op(1'b1, 8'h05);
    fetch(1'b0, 1'b0, 8'h00, 3, 2);
    chk("late_pc", pc, 8'h06);

    // Random traffic
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) < 7)
        fetch(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
              $urandom_range(0, 4), 1);
      else
        next_op(1'($urandom_range(0, 1)), 8'($urandom));
    end

`ifdef FETCH_TIMEOUT_EN
    // Ack on the last allowed WAIT cycle still completes normally
    imem[model_pc] = 16'h9ABC;
    fetch(1'b0, 1'b0, 8'h00, 15, 0);
    chk("ack15_err", fetch_err, 0);
    // No ack at all: abort after 15 WAIT cycles
    do_fetch = 1'b1;
    step();
    do_fetch = 1'b0;
    for (int unsigned k = 1; k <= 15; k++) begin
      #1;
      chk("to_busy", busy, 1);
      step();
    end
    chk("to_busy_done", busy, 0);
    chk("to_err", fetch_err, 1);
    chk("to_instr", instr, 0);
    #1;
    chk("to_req", mem_req, 0);
`endif

    repeat (3) step();
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
